dctq_frame_sequencer: RTL and testbench
=======================================

Name: dctq_frame_sequencer

Overview:
Frame-level scheduler above dctq_controller. It pushes a frame of cfg_nblocks 8x8 blocks through the DCTQ pipeline. It drives the controller's start/hold, pulls pixels from a valid/ready source and back-pressures from the coefficient sink. It appends one flush block so the last block's coefficients drain, counts dctq_valid beats, and pulses frame_done.

Parameters:
CNT_W, 16, width of block count and block index
BLK_PIX, 64, pixels/coefficients per block (fixed; 6-bit pixel counter)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  start request; sampled only in IDLE
cfg_nblocks  in  CNT_W  blocks in frame; latched on accepted frame_start
frame_busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle completion pulse
src_valid  in  1  pixel available at source
src_ready  out  1  pixel consumed this cycle
snk_ready  in  1  coefficient sink can accept
ctl_start  out  1  to dctq_controller start
ctl_hold  out  1  to dctq_controller hold
ctl_ready  in  1  from dctq_controller ready
ctl_dctq_valid  in  1  from dctq_controller dctq_valid
blk_idx  out  CNT_W  index of block currently fed (flush block = nblocks)
coef_cnt  out  CNT_W+6  dctq_valid beats counted this frame
err_spurious  out  1  sticky: dctq_valid seen in IDLE; cleared on accepted frame_start

Behaviour:
- Reset (async): state IDLE. All outputs 0. Internal pix_cnt 0, nblk 0. Reset mid-frame aborts silently; no frame_done.
- States: IDLE, FEED, FLUSH, DONE.
- IDLE, frame_start=1, cfg_nblocks!=0: latch nblk=cfg_nblocks; clear blk_idx, coef_cnt, pix_cnt, err_spurious; go to FEED next cycle.
- IDLE, frame_start=1, cfg_nblocks==0: frame_done pulses the next cycle; stay IDLE.
- frame_start outside IDLE is ignored. cfg_nblocks is not re-sampled mid-frame.
- advance = frame_busy & ~ctl_hold. pix_cnt increments on advance in FEED/FLUSH and wraps 63->0.
- FEED:
  - ctl_start=1.
  - ctl_hold = ~src_valid | ~snk_ready (combinational).
  - src_ready = ~ctl_hold.
  - On wrap, blk_idx++. When blk_idx reaches nblk, go to FLUSH.
- FLUSH: one extra block period of don't-care pixels. src_ready=0. ctl_hold = ~snk_ready.
  - ctl_start=1 except it drops to 0 from pix_cnt==62 onward, so the controller stops after cnt 63.
  - On wrap, go to DONE.
- DONE: ctl_start=0, ctl_hold=~snk_ready.
  - Exit condition: coef_cnt=={nblk,6'b0} and ctl_ready=1. On exit, frame_done pulses one cycle and state returns to IDLE.
- coef_cnt increments on every ctl_dctq_valid in any busy state. It saturates at {nblk,6'b0}; extra beats are ignored.
- ctl_dctq_valid in IDLE sets err_spurious.
- Simultaneous events:
  - pix_cnt wrap with a hold edge: wrap is suppressed while held.
  - src_valid low and snk_ready low together give a single ctl_hold.
  - A sink stall in FEED also stalls the source (src_ready=0).
- Width rules:
  - blk_idx compares against nblk at CNT_W bits.
  - Target {nblk,6'b0} is CNT_W+6 bits; no overflow for nblk up to 2^CNT_W-1.

Decomposition:
- Package dctq_pkg: BLK_PIX=64, PIX_W=6, state enum (IDLE/FEED/FLUSH/DONE), FLUSH_STOP=6'd62.
- No sub-module. The design is a single FSM plus pix/blk/coef counters; it is compact enough at about 200 lines.

Test Plan:
- nblocks=1, src_valid=snk_ready=1 constantly:
  - ctl_start high 126 cycles.
  - 64 ctl_dctq_valid beats; coef_cnt=64.
  - frame_done exactly once, after ctl_ready=1; blk_idx=1.
- nblocks=3, src_valid low 5 cycles at pix_cnt=10 of block 1:
  - ctl_hold high exactly 5 cycles; pix_cnt frozen at 10; src_ready=0 for those 5 cycles.
  - 192 beats; frame_done once.
- snk_ready low 4 cycles during flush: ctl_hold high 4 cycles, src_ready stays 0, coef_cnt still reaches 64*nblk.
- frame_start with cfg_nblocks=0: frame_done pulses next cycle, frame_busy never rises, ctl_start stays 0.
- frame_start pulsed in FEED with different cfg_nblocks: ignored; frame completes with the original nblk count.
- reset_n low at block 1, pixel 30: all outputs 0 immediately. A new frame_start with nblocks=2 then completes with 128 beats. ctl_dctq_valid injected in IDLE sets err_spurious.

Source files
------------

// File: rtl/dctq_pkg.sv
// Shared constants and state type for the DCTQ frame sequencer.
package dctq_pkg;

  localparam int BLK_PIX = 64;
  localparam int PIX_W   = 6;

  localparam logic [PIX_W-1:0] PIX_LAST   = 6'd63;
  // Last-but-one pixel slots of the flush block: start is dropped here so the
  // controller finishes its current count and then stops.
  localparam logic [PIX_W-1:0] FLUSH_STOP = 6'd62;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dctq_frame_sequencer.sv
// Frame-level scheduler above dctq_controller: feeds nblocks 8x8 blocks,
// appends one flush block, counts coefficient beats and signals completion.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for frame_start; dctq_valid here is spurious
//   FEED  | moving source pixels into the controller, one per advance
//   FLUSH | one block of don't-care pixels so the last block drains
//   DONE  | waiting for all coefficients and controller ready
module dctq_frame_sequencer
  import dctq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [CNT_W-1:0]   cfg_nblocks,
  output logic               frame_busy,
  output logic               frame_done,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic               snk_ready,
  output logic               ctl_start,
  output logic               ctl_hold,
  input  logic               ctl_ready,
  input  logic               ctl_dctq_valid,
  output logic [CNT_W-1:0]   blk_idx,
  output logic [CNT_W+5:0]   coef_cnt,
  output logic               err_spurious
);

  state_e                 state_q, state_d;
  logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]       nblk_q, nblk_d;
  logic [CNT_W-1:0]       blk_idx_q, blk_idx_d;
  logic [CNT_W+5:0]       coef_cnt_q, coef_cnt_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic [CNT_W+5:0]       coef_tgt;
  logic                   advance;
  logic                   pix_wrap;

  assign coef_tgt   = {nblk_q, {PIX_W{1'b0}}};
  assign frame_busy = (state_q != IDLE);
  assign advance    = frame_busy & ~ctl_hold;
  assign pix_wrap   = advance & (pix_cnt_q == PIX_LAST);

  assign frame_done   = done_q;
  assign blk_idx      = blk_idx_q;
  assign coef_cnt     = coef_cnt_q;
  assign err_spurious = err_q;

  // Controller handshake outputs, decoded from state and the live stall inputs.
  always_comb begin
    ctl_start = 1'b0;
    ctl_hold  = 1'b0;
    src_ready = 1'b0;
    unique case (state_q)
      FEED: begin
        ctl_start = 1'b1;
        ctl_hold  = ~src_valid | ~snk_ready;
        src_ready = src_valid & snk_ready;
      end
      FLUSH: begin
        ctl_start = (pix_cnt_q < FLUSH_STOP);
        ctl_hold  = ~snk_ready;
      end
      DONE: begin
        ctl_hold  = ~snk_ready;
      end
      default: begin
        ctl_start = 1'b0;
      end
    endcase
  end

  // Next-state logic for the FSM and the pixel/block/coefficient counters.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    nblk_d     = nblk_q;
    blk_idx_d  = blk_idx_q;
    coef_cnt_d = coef_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;

    if (frame_busy && ctl_dctq_valid && (coef_cnt_q < coef_tgt))
      coef_cnt_d = coef_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (ctl_dctq_valid)
          err_d = 1'b1;
        if (frame_start) begin
          if (cfg_nblocks != '0) begin
            nblk_d     = cfg_nblocks;
            blk_idx_d  = '0;
            coef_cnt_d = '0;
            pix_cnt_d  = '0;
            err_d      = 1'b0;
            state_d    = FEED;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (advance)
          pix_cnt_d = pix_cnt_q + 1'b1;
        if (pix_wrap) begin
          blk_idx_d = blk_idx_q + 1'b1;
          if (blk_idx_d == nblk_q)
            state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (advance)
          pix_cnt_d = pix_cnt_q + 1'b1;
        if (pix_wrap)
          state_d = DONE;
      end
      DONE: begin
        if ((coef_cnt_q == coef_tgt) && ctl_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset aborts any frame in flight silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      nblk_q     <= '0;
      blk_idx_q  <= '0;
      coef_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      nblk_q     <= nblk_d;
      blk_idx_q  <= blk_idx_d;
      coef_cnt_q <= coef_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dctq_frame_sequencer.sv
// Randomized bench for dctq_frame_sequencer. The reference model tracks a
// frame only by counts: accepted pixels, advances, start cycles and delivered
// coefficient beats, and derives the expected outputs from those counts.
module tb_dctq_frame_sequencer;

  localparam int CNT_W = 16;
  localparam int TIMEOUT = 4000;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               frame_start;
  logic [CNT_W-1:0]   cfg_nblocks;
  logic               frame_busy;
  logic               frame_done;
  logic               src_valid;
  logic               src_ready;
  logic               snk_ready;
  logic               ctl_start;
  logic               ctl_hold;
  logic               ctl_ready;
  logic               ctl_dctq_valid;
  logic [CNT_W-1:0]   blk_idx;
  logic [CNT_W+5:0]   coef_cnt;
  logic               err_spurious;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dctq_frame_sequencer #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .cfg_nblocks    (cfg_nblocks),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .snk_ready      (snk_ready),
    .ctl_start      (ctl_start),
    .ctl_hold       (ctl_hold),
    .ctl_ready      (ctl_ready),
    .ctl_dctq_valid (ctl_dctq_valid),
    .blk_idx        (blk_idx),
    .coef_cnt       (coef_cnt),
    .err_spurious   (err_spurious)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    frame_start    = 1'b0;
    cfg_nblocks    = '0;
    src_valid      = 1'b0;
    snk_ready      = 1'b0;
    ctl_ready      = 1'b0;
    ctl_dctq_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   frame_busy,   0);
    chk({tag, "_done"},   frame_done,   0);
    chk({tag, "_srdy"},   src_ready,    0);
    chk({tag, "_start"},  ctl_start,    0);
    chk({tag, "_hold"},   ctl_hold,     0);
    chk({tag, "_blk"},    blk_idx,      0);
    chk({tag, "_coef"},   coef_cnt,     0);
    chk({tag, "_err"},    err_spurious, 0);
  endtask

  // One frame of n blocks. stall: 0 random only, 1 five-cycle source gap at
  // block 1 pixel 10, 2 four-cycle sink stall at flush pixel 10.
  // abort_hs > 0 asserts reset after that many accepted pixels.
  task automatic run_frame(input int n, input int p_src, input int p_snk, input int p_rdy,
                           input int stall, input int abort_hs);
    int tgt, hs, adv, beats, pend, cyc, st_left;
    int hs_dut, sadv_dut, hold_dut;
    int e_hold, e_start, e_srdy, e_blk, e_coef, e_done, e_busy;
    bit stalled, fin, aborted, exit_prev, exit_pred, feed, flush, hold_exp, start_exp;
    tgt = 64 * n;
    hs = 0; adv = 0; beats = 0; pend = 0; cyc = 0; st_left = 0;
    hs_dut = 0; sadv_dut = 0; hold_dut = 0;
    e_hold = 0; e_start = 0; e_srdy = 0; e_blk = 0; e_coef = 0; e_done = 0; e_busy = 0;
    stalled = 0; fin = 0; aborted = 0; exit_prev = 0;

    @(posedge clk); #1;
    drive_idle();
    frame_start = 1'b1;
    cfg_nblocks = CNT_W'(n);
    snk_ready   = 1'b1;
    @(negedge clk);
    chk("idle_before_start", frame_busy, 0);
    @(posedge clk); #1;
    chk("busy_after_start", frame_busy, 1);
    chk("err_clear_on_start", err_spurious, 0);

    while (!fin && cyc < TIMEOUT) begin
      if (abort_hs > 0 && hs == abort_hs) begin
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        #2;
        reset_n = 1'b1;
        aborted = 1;
        break;
      end
      frame_start    = 1'b0;
      src_valid      = ($urandom_range(99) < p_src);
      snk_ready      = ($urandom_range(99) < p_snk);
      ctl_ready      = ($urandom_range(99) < p_rdy);
      ctl_dctq_valid = 1'b0;
      if (!stalled && stall == 1 && hs == 64 + 10) begin
        stalled = 1; st_left = 5;
      end
      if (!stalled && stall == 2 && hs == tgt && adv - tgt == 10) begin
        stalled = 1; st_left = 4;
      end
      if (st_left > 0) begin
        if (stall == 1) src_valid = 1'b0;
        else snk_ready = 1'b0;
        st_left--;
      end
      if (frame_busy) begin
        if (pend > 0 && $urandom_range(99) < 60) begin
          ctl_dctq_valid = 1'b1;
          pend--;
        end else if ($urandom_range(99) < 4) begin
          ctl_dctq_valid = 1'b1;
        end
        if (cyc == 40 || $urandom_range(99) < 2) begin
          frame_start = 1'b1;
          cfg_nblocks = CNT_W'($urandom_range(9, 1));
        end
      end
      @(negedge clk);

      if (exit_prev) begin
        chk("frame_done_pulse", frame_done, 1);
        chk("idle_after_done", frame_busy, 0);
        chk("start_low_after_done", ctl_start, 0);
        fin = 1;
      end else begin
        feed      = (hs < tgt);
        flush     = !feed && (adv < tgt + 64);
        hold_exp  = feed ? (!src_valid || !snk_ready) : !snk_ready;
        start_exp = feed || (flush && (adv - tgt) < 62);
        if (frame_busy !== 1'b1) e_busy++;
        if (ctl_hold !== hold_exp) e_hold++;
        if (ctl_start !== start_exp) e_start++;
        if (src_ready !== (feed && !hold_exp)) e_srdy++;
        if (blk_idx !== CNT_W'(hs / 64)) e_blk++;
        if (coef_cnt !== (CNT_W+6)'((beats < tgt) ? beats : tgt)) e_coef++;
        if (frame_done !== 1'b0) e_done++;
        exit_pred = (adv >= tgt + 64) && (beats >= tgt) && ctl_ready;
        if (feed && !hold_exp) hs++;
        if (!hold_exp) adv++;
        if (src_valid && src_ready) begin
          hs_dut++;
          pend++;
        end
        if (ctl_start && !ctl_hold) sadv_dut++;
        if (ctl_hold) hold_dut++;
        if (ctl_dctq_valid) beats++;
        exit_prev = exit_pred;
        cyc++;
        @(posedge clk); #1;
      end
    end

    drive_idle();
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_done_after_abort", frame_done, 0);
      end
      return;
    end

    chk("frame_timeout", fin, 1);
    chk("busy_rule", e_busy, 0);
    chk("hold_rule", e_hold, 0);
    chk("start_rule", e_start, 0);
    chk("src_ready_rule", e_srdy, 0);
    chk("blk_idx_track", e_blk, 0);
    chk("coef_cnt_track", e_coef, 0);
    chk("done_early", e_done, 0);
    chk("pixels_accepted", hs_dut, tgt);
    chk("start_cycles", sadv_dut, tgt + 62);
    if (stall != 0)
      chk("hold_cycles", hold_dut, (stall == 1) ? 5 : 4);
    chk("coef_final", coef_cnt, tgt);
    chk("blk_final", blk_idx, n);
    chk("err_quiet", err_spurious, 0);
    repeat (2) begin
      @(negedge clk);
      chk("done_single", frame_done, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    run_frame(1, 100, 100, 50, 0, 0);
    run_frame(3, 100, 100, 50, 1, 0);
    run_frame(2, 100, 100, 50, 2, 0);

    @(posedge clk); #1;
    frame_start = 1'b1;
    cfg_nblocks = '0;
    @(negedge clk);
    chk("zero_no_done_yet", frame_done, 0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("zero_done_pulse", frame_done, 1);
    chk("zero_busy", frame_busy, 0);
    chk("zero_start", ctl_start, 0);
    @(negedge clk);
    chk("zero_done_once", frame_done, 0);

    run_frame(2, 100, 100, 100, 0, 64 + 30);
    run_frame(2, 100, 100, 100, 0, 0);

    @(posedge clk); #1;
    ctl_dctq_valid = 1'b1;
    @(negedge clk);
    chk("err_before_spurious", err_spurious, 0);
    @(posedge clk); #1;
    ctl_dctq_valid = 1'b0;
    @(negedge clk);
    chk("err_spurious_set", err_spurious, 1);
    chk("coef_idle_no_count", coef_cnt, 128);

    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(4, 1), $urandom_range(100, 60), $urandom_range(100, 60),
                $urandom_range(100, 30), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
